snake_body_engine: RTL and testbench
====================================

SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, meaning segment storage depth (>=4).
REQ-002 SHALL have parameter COORD_W, default 6, meaning coordinate width in grid cells.
REQ-003 SHALL have parameters GRID_W, default 40, and GRID_H, default 30, meaning playfield size in cells.
REQ-004 SHALL have parameters START_X, default 20, START_Y, default 15, and START_LEN, default 3, meaning the initial head cell and length.
REQ-005 SHALL have port clock  in  1  meaning the single clock; all state on the rising edge.
REQ-006 SHALL have port resetn  in  1  meaning asynchronous, active-low reset.
REQ-007 SHALL have port tick  in  1  meaning move-step strobe, one cycle wide.
REQ-008 SHALL have ports up, down, left, right  in  1 each  meaning direction buttons, already synchronised.
REQ-009 SHALL have ports grow  in  1  meaning grow-request pulse, and wrap_mode  in  1  meaning 1 = wrap at edges, 0 = walls kill.
REQ-010 SHALL have port rd_idx  in  $clog2(MAX_LEN)  meaning segment read index, 0 = head.
REQ-011 SHALL have ports rd_x, rd_y  out  COORD_W  meaning segment rd_idx coordinates, combinational; and rd_valid  out  1  meaning rd_idx < length.
REQ-012 SHALL have ports head_x, head_y  out  COORD_W; length  out  $clog2(MAX_LEN+1); busy, step_done, game_over  out  1.

Function
REQ-013 Direction register SHALL hold NONE, UP, DOWN, LEFT or RIGHT; it updates every cycle when exactly one button is high.
REQ-014 A request for the reverse of the current direction, or multiple buttons high, SHALL be ignored.
REQ-015 UP SHALL decrement y, DOWN increment y, LEFT decrement x, RIGHT increment x, each by one cell.
REQ-016 FSM states SHALL be IDLE, CHECK, COMMIT, DEAD.
REQ-017 IDLE: tick with direction not NONE SHALL compute next head, latch it, and enter CHECK; tick with direction NONE SHALL be ignored.
REQ-018 With wrap_mode=0, a next head outside 0..GRID_W-1 / 0..GRID_H-1 SHALL go directly to DEAD.
REQ-019 With wrap_mode=1, x SHALL wrap 0<->GRID_W-1 and y wrap 0<->GRID_H-1.
REQ-020 CHECK SHALL compare the next head against one segment per cycle, indices 0..length-2, or 0..length-1 when growth is pending at CHECK entry.
REQ-021 A match in CHECK SHALL go to DEAD at the next edge; otherwise CHECK SHALL go to COMMIT after the last index (length-1 or length cycles).
REQ-022 COMMIT SHALL shift segment i to i+1 for all i, write the next head to segment 0, apply pending growth, pulse step_done for one cycle, and return to IDLE.
REQ-023 A grow pulse SHALL set a sticky pending flag in any state.
REQ-024 COMMIT SHALL clear the pending flag and increment length when length < MAX_LEN; at MAX_LEN length SHALL saturate and the flag SHALL clear.
REQ-025 busy SHALL be high in CHECK and COMMIT; tick while busy SHALL be ignored, not queued.
REQ-026 DEAD SHALL be absorbing: game_over high, segments, length and direction frozen, ticks ignored until reset.
REQ-027 A simultaneous grow and COMMIT SHALL apply the pulse to the next step, not the current one.

Reset
REQ-028 Reset SHALL set state IDLE, direction NONE, pending clear, length=START_LEN, segment i=(START_X-i, START_Y) for i<START_LEN, others zero, busy=step_done=game_over=0.
REQ-029 Reset asserted mid-CHECK or mid-COMMIT SHALL abort the step with no partial shift visible.

Structure
REQ-030 Package snake_pkg SHALL hold dir_t, state_t, and the direction encodings; MAX_LEN and grid parameters SHALL stay module parameters.
REQ-031 Next-head computation with wall/wrap detection SHALL be sub-module snake_next_head (combinational, parametrised by COORD_W, GRID_W, GRID_H).

Verification
REQ-032 Reset, right held, tick -> after 3 cycles (CHECK 2 + COMMIT) step_done=1, head=(21,15), segment 2=(19,15), length=3.
REQ-033 Moving RIGHT, press left, tick -> direction stays RIGHT, head x increments.
REQ-034 wrap_mode=0, head at x=39 moving RIGHT, tick -> game_over=1 next cycle, head unchanged; repeat with wrap_mode=1 -> head x=0.
REQ-035 grow pulse then tick -> length 3->4 and old tail retained; at length=MAX_LEN a further grow leaves length=MAX_LEN.
REQ-036 Length 5 body forming a loop, steer into segment 3 -> game_over=1; steer into the tail cell without grow -> no game_over.
REQ-037 Tick during busy -> ignored, exactly one step_done; resetn low mid-CHECK -> initial body restored.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake body engine: direction and FSM state encodings.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_COMMIT = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  function automatic dir_t dir_reverse(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head cell: one step in dir_i, with edge wrap or wall detection.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int COORD_W = 6,
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  dir_t               dir_i,
  input  logic               wrap_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               wall_o
);

  localparam logic [COORD_W-1:0] XMAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  always_comb begin
    x_o    = x_i;
    y_o    = y_i;
    wall_o = 1'b0;
    case (dir_i)
      DIR_UP:
        if (y_i == '0) begin
          wall_o = !wrap_i;
          y_o    = YMAX;
        end else y_o = y_i - ONE;
      DIR_DOWN:
        if (y_i == YMAX) begin
          wall_o = !wrap_i;
          y_o    = '0;
        end else y_o = y_i + ONE;
      DIR_LEFT:
        if (x_i == '0) begin
          wall_o = !wrap_i;
          x_o    = XMAX;
        end else x_o = x_i - ONE;
      DIR_RIGHT:
        if (x_i == XMAX) begin
          wall_o = !wrap_i;
          x_o    = '0;
        end else x_o = x_i + ONE;
      default: ;
    endcase
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body store and step sequencer: latch next head, scan body for a hit one
// segment per cycle, then shift the body in a single commit cycle.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 32,
  parameter int COORD_W   = 6,
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int START_X   = 20,
  parameter int START_Y   = 15,
  parameter int START_LEN = 3
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         tick,
  input  logic                         up,
  input  logic                         down,
  input  logic                         left,
  input  logic                         right,
  input  logic                         grow,
  input  logic                         wrap_mode,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
  output logic [COORD_W-1:0]           rd_x,
  output logic [COORD_W-1:0]           rd_y,
  output logic                         rd_valid,
  output logic [COORD_W-1:0]           head_x,
  output logic [COORD_W-1:0]           head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         busy,
  output logic                         step_done,
  output logic                         game_over
);

  localparam int IDXW = $clog2(MAX_LEN);
  localparam int LENW = $clog2(MAX_LEN + 1);

  state_t                            state_q;
  dir_t                              dir_q, btn_dir;
  logic [MAX_LEN-1:0][COORD_W-1:0]   seg_x_q, seg_y_q;
  logic [COORD_W-1:0]                nh_x_q, nh_y_q, calc_x, calc_y;
  logic                              calc_wall, hit;
  logic [LENW-1:0]                   len_q;
  logic [IDXW-1:0]                   chk_idx_q, chk_last_q, chk_last_d;
  logic                              pend_q, grow_lat_q, busy_q, done_q, over_q;

  always_comb begin
    case ({up, down, left, right})
      4'b1000: btn_dir = DIR_UP;
      4'b0100: btn_dir = DIR_DOWN;
      4'b0010: btn_dir = DIR_LEFT;
      4'b0001: btn_dir = DIR_RIGHT;
      default: btn_dir = DIR_NONE;
    endcase
  end

  snake_next_head #(
    .COORD_W(COORD_W),
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_head (
    .x_i   (seg_x_q[0]),
    .y_i   (seg_y_q[0]),
    .dir_i (dir_q),
    .wrap_i(wrap_mode),
    .x_o   (calc_x),
    .y_o   (calc_y),
    .wall_o(calc_wall)
  );

  // With growth pending the tail stays put, so it must be scanned as well.
  assign chk_last_d = pend_q ? IDXW'(len_q - LENW'(1)) : IDXW'(len_q - LENW'(2));
  assign hit        = (seg_x_q[chk_idx_q] == nh_x_q) && (seg_y_q[chk_idx_q] == nh_y_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_NONE;
      pend_q     <= 1'b0;
      grow_lat_q <= 1'b0;
      len_q      <= LENW'(START_LEN);
      nh_x_q     <= '0;
      nh_y_q     <= '0;
      chk_idx_q  <= '0;
      chk_last_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      over_q     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < START_LEN) ? COORD_W'(START_X - i) : '0;
        seg_y_q[i] <= (i < START_LEN) ? COORD_W'(START_Y) : '0;
      end
    end else begin
      done_q <= 1'b0;
      if (grow) pend_q <= 1'b1;
      if (state_q != S_DEAD && btn_dir != DIR_NONE && btn_dir != dir_reverse(dir_q))
        dir_q <= btn_dir;

      case (state_q)
        S_IDLE:
          if (tick && dir_q != DIR_NONE) begin
            if (calc_wall) begin
              state_q <= S_DEAD;
              over_q  <= 1'b1;
            end else begin
              nh_x_q     <= calc_x;
              nh_y_q     <= calc_y;
              chk_idx_q  <= '0;
              chk_last_q <= chk_last_d;
              grow_lat_q <= pend_q;
              busy_q     <= 1'b1;
              state_q    <= S_CHECK;
            end
          end
        S_CHECK:
          if (hit) begin
            state_q <= S_DEAD;
            busy_q  <= 1'b0;
            over_q  <= 1'b1;
          end else if (chk_idx_q == chk_last_q) begin
            state_q <= S_COMMIT;
          end else begin
            chk_idx_q <= chk_idx_q + IDXW'(1);
          end
        S_COMMIT: begin
          seg_x_q <= {seg_x_q[MAX_LEN-2:0], nh_x_q};
          seg_y_q <= {seg_y_q[MAX_LEN-2:0], nh_y_q};
          // Only growth seen at CHECK entry is consumed; a grow arriving now waits.
          if (grow_lat_q) begin
            if (len_q < LENW'(MAX_LEN)) len_q <= len_q + LENW'(1);
            pend_q <= grow;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign rd_x      = seg_x_q[rd_idx];
  assign rd_y      = seg_y_q[rd_idx];
  assign rd_valid  = LENW'(rd_idx) < len_q;
  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = len_q;
  assign busy      = busy_q;
  assign step_done = done_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: timeline-level body model checked every cycle, plus literal pins.
module tb_snake_body_engine;

  localparam int MAX_LEN = 32;
  localparam int GW = 40, GH = 30, SX = 20, SY = 15, SL = 3;

  logic       clock = 0, resetn = 0, tick = 0;
  logic       up = 0, down = 0, left = 0, right = 0, grow = 0, wrap_mode = 0;
  logic [4:0] rd_idx = 0;
  logic [5:0] rd_x, rd_y, head_x, head_y, length;
  logic       rd_valid, busy, step_done, game_over;

  snake_body_engine dut (
    .clock(clock), .resetn(resetn), .tick(tick),
    .up(up), .down(down), .left(left), .right(right),
    .grow(grow), .wrap_mode(wrap_mode), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
    .head_x(head_x), .head_y(head_y), .length(length),
    .busy(busy), .step_done(step_done), .game_over(game_over)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  bit run_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: body as a queue (front = head); a step is "busy for N cycles, then commit or die".
  int mbx[$], mby[$];
  int mlen, mdir, mrem, mnx, mny;
  bit mpend, mdead, mdone, mfate_dead, mgu;

  function automatic int rev(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mbx.delete(); mby.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      mbx.push_back(i < SL ? SX - i : 0);
      mby.push_back(i < SL ? SY : 0);
    end
    mlen = SL; mdir = 0; mrem = 0; mpend = 0; mdead = 0; mdone = 0; mfate_dead = 0; mgu = 0;
  endtask

  initial begin
    int nx, ny, n, k, nd, btn;
    bit g, dead0, wall;
    model_reset();
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) model_reset();
      else begin
        g = grow; dead0 = mdead; mdone = 0;
        btn = int'(up) + int'(down) + int'(left) + int'(right);
        if (!mdead && mrem == 0 && tick && mdir != 0) begin
          nx = mbx[0] + (mdir == 4) - (mdir == 3);
          ny = mby[0] + (mdir == 2) - (mdir == 1);
          wall = 0;
          if (nx < 0 || nx >= GW) begin if (wrap_mode) nx = (nx + GW) % GW; else wall = 1; end
          if (ny < 0 || ny >= GH) begin if (wrap_mode) ny = (ny + GH) % GH; else wall = 1; end
          if (wall) mdead = 1;
          else begin
            n = mpend ? mlen : mlen - 1;
            k = -1;
            for (int i = 0; i < n; i++)
              if (k < 0 && mbx[i] == nx && mby[i] == ny) k = i;
            mfate_dead = (k >= 0);
            mrem = (k >= 0) ? k + 1 : n + 1;
            mgu = mpend; mnx = nx; mny = ny;
          end
          mpend = mpend | g;
        end else if (mrem > 0) begin
          mrem--;
          if (mrem == 0 && mfate_dead) begin
            mdead = 1; mpend = mpend | g;
          end else if (mrem == 0) begin
            mbx.push_front(mnx); mby.push_front(mny);
            void'(mbx.pop_back()); void'(mby.pop_back());
            mdone = 1;
            if (mgu) begin
              if (mlen < MAX_LEN) mlen++;
              mpend = g;
            end else mpend = mpend | g;
          end else mpend = mpend | g;
        end else mpend = mpend | g;
        if (!dead0 && btn == 1) begin
          nd = up ? 1 : down ? 2 : left ? 3 : 4;
          if (nd != rev(mdir)) mdir = nd;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (run_chk) begin
      chk("head_x", head_x, mbx[0]);
      chk("head_y", head_y, mby[0]);
      chk("length", length, mlen);
      chk("busy", busy, mrem > 0);
      chk("step_done", step_done, mdone);
      chk("game_over", game_over, mdead);
      chk("rd_x", rd_x, mbx[rd_idx]);
      chk("rd_y", rd_y, mby[rd_idx]);
      chk("rd_valid", rd_valid, int'(rd_idx) < mlen);
    end
  end

  task automatic cyc();
    @(posedge clock); #2;
  endtask

  task automatic press(input int d);
    up = (d == 1); down = (d == 2); left = (d == 3); right = (d == 4);
    cyc();
    up = 0; down = 0; left = 0; right = 0;
  endtask

  task automatic pulse_grow();
    grow = 1; cyc(); grow = 0;
  endtask

  task automatic do_reset();
    resetn = 0; cyc(); cyc(); resetn = 1; cyc();
  endtask

  task automatic step(input string nm, output int lat);
    tick = 1; cyc(); tick = 0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      if (step_done || game_over) break;
      cyc(); lat++;
    end
    chk({nm, "_complete"}, int'(step_done | game_over), 1);
  endtask

  task automatic lit_seg(input string nm, input int idx, input int ex, input int ey);
    rd_idx = 5'(idx); #1;
    chk({nm, "_x"}, rd_x, ex);
    chk({nm, "_y"}, rd_y, ey);
  endtask

  initial begin
    int lat, cnt;
    cyc(); cyc();
    run_chk = 1;
    resetn = 1; cyc();
    chk("rst_head_x", head_x, 20); chk("rst_head_y", head_y, 15);
    chk("rst_len", length, 3); chk("rst_over", game_over, 0); chk("rst_busy", busy, 0);
    lit_seg("rst_seg2", 2, 18, 15);

    // First step right: three cycles of latency
    press(4); step("a", lat);
    chk("a_latency", lat, 3); chk("a_done", step_done, 1);
    chk("a_head_x", head_x, 21); chk("a_head_y", head_y, 15); chk("a_len", length, 3);
    lit_seg("a_seg2", 2, 19, 15);

    // Reverse request ignored
    press(3); step("b", lat);
    chk("b_head_x", head_x, 22); chk("b_head_y", head_y, 15);

    // Tick while busy is dropped
    tick = 1; cyc(); tick = 0; cyc();
    chk("c_busy", busy, 1);
    tick = 1; cyc(); tick = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (step_done) cnt++;
      cyc();
    end
    chk("c_done_cnt", cnt, 1); chk("c_head_x", head_x, 23);

    // Growth keeps the old tail
    pulse_grow(); step("d", lat);
    chk("d_len", length, 4); lit_seg("d_tail", 3, 21, 15);

    // Loop into segment 3
    pulse_grow(); step("e0", lat); chk("e_len", length, 5);
    press(1); step("e1", lat);
    press(3); step("e2", lat);
    press(2); step("e3", lat);
    chk("e_over", game_over, 1); chk("e_head_x", head_x, 24); chk("e_head_y", head_y, 14);
    step("e4", lat); chk("e_dead_head_x", head_x, 24); chk("e_dead_len", length, 5);

    // Steering into the vacating tail is legal
    do_reset();
    pulse_grow(); press(4); step("t0", lat);
    press(1); step("t1", lat);
    press(3); step("t2", lat);
    press(2); step("t3", lat);
    chk("t_over", game_over, 0); chk("t_head_x", head_x, 20); chk("t_head_y", head_y, 15);
    chk("t_len", length, 4);

    // Reset in the middle of CHECK
    tick = 1; cyc(); tick = 0;
    chk("r_busy", busy, 1);
    resetn = 0; #1;
    chk("r_busy0", busy, 0); chk("r_head_x", head_x, 20); chk("r_head_y", head_y, 15);
    chk("r_len", length, 3);
    lit_seg("r_seg1", 1, 19, 15);
    cyc(); resetn = 1; cyc();

    // Wall kills at x=39
    wrap_mode = 0; press(4);
    for (int i = 0; i < 19; i++) step("w", lat);
    chk("w_head_x", head_x, 39);
    tick = 1; cyc(); tick = 0;
    chk("w_over", game_over, 1); chk("w_head_x_frozen", head_x, 39);

    // Wrap to x=0
    do_reset(); wrap_mode = 1; press(4);
    for (int i = 0; i < 20; i++) step("wr", lat);
    chk("wr_head_x", head_x, 0); chk("wr_over", game_over, 0);

    // Saturation at MAX_LEN
    do_reset(); wrap_mode = 1; press(4);
    for (int i = 0; i < 30; i++) begin
      pulse_grow(); step("s", lat);
      if (i == 28) chk("s_len_full", length, 32);
    end
    chk("s_len_sat", length, 32); chk("s_over", game_over, 0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
